// File: rtl/rvfi_check_ctrl.sv
// rvfi_check_ctrl: sequences checker reset, the one-shot trig pulse and the
// delayed check pulse from either the cycle count or the cumulative retirement count.
module rvfi_check_ctrl #(
    parameter int NRET         = 1,
    parameter int RESET_CYCLES = 1,
    parameter int TRIG_MODE    = 0,
    parameter int TRIG_CYCLE   = 10,
    parameter int TRIG_RETIRE  = 1,
    parameter int CHECK_GAP    = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NRET-1:0] rvfi_valid,
    output logic            chk_reset,
    output logic            trig,
    output logic            check,
    output logic [7:0]      cycle,
    output logic [15:0]     retired,
    output logic [1:0]      state,
    output logic            timeout
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ARMED      = 2'd1,
        ST_WAIT_CHECK = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    localparam logic [31:0] RESET_CYCLES_W = 32'(RESET_CYCLES);
    localparam logic [31:0] TRIG_CYCLE_W   = 32'(TRIG_CYCLE);
    localparam logic [16:0] TRIG_RETIRE_W  = 17'(TRIG_RETIRE);
    localparam logic [31:0] CHECK_GAP_W    = 32'(CHECK_GAP);
    localparam bit          GAP_ZERO       = (CHECK_GAP == 0);

    logic [7:0]  cycle_q, cycle_d;
    logic [15:0] retired_q, retired_d;
    logic [7:0]  gap_q, gap_d;
    state_e      state_q, state_d;
    logic        timeout_q, timeout_d;

    logic [16:0] retire_cnt;
    logic [16:0] retire_sum;
    logic        trig_cond;
    logic        gap_hit;

    // NOTE: combinational blocks use blocking '=' and give every target a
    // default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < NRET; i++) begin
            retire_cnt = retire_cnt + 17'(rvfi_valid[i]);
        end
    end

    // 17-bit sum keeps the carry so the mode-1 compare sees the unsaturated total.
    assign retire_sum = {1'b0, retired_q} + retire_cnt;

    generate
        if (RESET_CYCLES <= 0) begin : g_no_chk_reset
            assign chk_reset = 1'b0;
        end else begin : g_chk_reset
            assign chk_reset = ({24'd0, cycle_q} < RESET_CYCLES_W);
        end

        if (TRIG_MODE == 0) begin : g_trig_cycle
            assign trig_cond = ({24'd0, cycle_q} == TRIG_CYCLE_W);
        end else begin : g_trig_retire
            assign trig_cond = (retire_sum >= TRIG_RETIRE_W);
        end
    endgenerate

    assign cycle_d = (cycle_q == 8'hFF) ? cycle_q : cycle_q + 8'd1;
    assign gap_hit = (({24'd0, gap_q} + 32'd1) == CHECK_GAP_W);

    always_comb begin
        retired_d = retired_q;
        if (!chk_reset) begin
            retired_d = retire_sum[16] ? 16'hFFFF : retire_sum[15:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        timeout_d = timeout_q;
        trig      = 1'b0;
        check     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!chk_reset) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (trig_cond) begin
                    trig  = 1'b1;
                    gap_d = '0;
                    if (GAP_ZERO) begin
                        check   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_CHECK;
                    end
                end else if (cycle_q == 8'hFF) begin
                    // Cycle counter saturated without the trigger ever firing.
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_WAIT_CHECK: begin
                gap_d = gap_q + 8'd1;
                if (gap_hit) begin
                    check   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            retired_q <= '0;
            gap_q     <= '0;
            state_q   <= ST_IDLE;
            timeout_q <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
            gap_q     <= gap_d;
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    assign cycle   = cycle_q;
    assign retired = retired_q;
    assign state   = state_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rvfi_check_ctrl.sv
// Self-checking bench: six differently parameterised instances run side by side
// against a timeline model of the trigger/check schedule, plus a directed table.
module tb_rvfi_check_ctrl;

    localparam int NI = 6;

    typedef struct {
        int nret;
        int rc;
        int mode;
        int tc;
        int tr;
        int gap;
    } cfg_t;

    typedef struct {
        logic [1:0]  valid;
        logic        exp_trig;
        logic [15:0] exp_retired;
        logic [1:0]  exp_state;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  vld     [NI];
    logic        chk_w   [NI];
    logic        trig_w  [NI];
    logic        check_w [NI];
    logic        to_w    [NI];
    logic [7:0]  cyc_w   [NI];
    logic [15:0] ret_w   [NI];
    logic [1:0]  st_w    [NI];

    cfg_t cfg    [NI];
    vec_t tbl    [8];
    int   n;
    int   racc   [NI];
    int   trig_n [NI];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rvfi_check_ctrl #(.NRET(1), .RESET_CYCLES(1), .TRIG_MODE(0), .TRIG_CYCLE(10), .TRIG_RETIRE(1), .CHECK_GAP(10)) u0 (
        .clock(clk), .reset(rst), .rvfi_valid(vld[0][0:0]), .chk_reset(chk_w[0]), .trig(trig_w[0]),
        .check(check_w[0]), .cycle(cyc_w[0]), .retired(ret_w[0]), .state(st_w[0]), .timeout(to_w[0]));
    rvfi_check_ctrl #(.NRET(2), .RESET_CYCLES(1), .TRIG_MODE(1), .TRIG_CYCLE(10), .TRIG_RETIRE(3), .CHECK_GAP(10)) u1 (
        .clock(clk), .reset(rst), .rvfi_valid(vld[1]), .chk_reset(chk_w[1]), .trig(trig_w[1]),
        .check(check_w[1]), .cycle(cyc_w[1]), .retired(ret_w[1]), .state(st_w[1]), .timeout(to_w[1]));
    rvfi_check_ctrl #(.NRET(1), .RESET_CYCLES(1), .TRIG_MODE(0), .TRIG_CYCLE(7), .TRIG_RETIRE(1), .CHECK_GAP(0)) u2 (
        .clock(clk), .reset(rst), .rvfi_valid(vld[2][0:0]), .chk_reset(chk_w[2]), .trig(trig_w[2]),
        .check(check_w[2]), .cycle(cyc_w[2]), .retired(ret_w[2]), .state(st_w[2]), .timeout(to_w[2]));
    rvfi_check_ctrl #(.NRET(1), .RESET_CYCLES(1), .TRIG_MODE(1), .TRIG_CYCLE(10), .TRIG_RETIRE(5), .CHECK_GAP(10)) u3 (
        .clock(clk), .reset(rst), .rvfi_valid(vld[3][0:0]), .chk_reset(chk_w[3]), .trig(trig_w[3]),
        .check(check_w[3]), .cycle(cyc_w[3]), .retired(ret_w[3]), .state(st_w[3]), .timeout(to_w[3]));
    rvfi_check_ctrl #(.NRET(1), .RESET_CYCLES(3), .TRIG_MODE(1), .TRIG_CYCLE(10), .TRIG_RETIRE(4), .CHECK_GAP(2)) u4 (
        .clock(clk), .reset(rst), .rvfi_valid(vld[4][0:0]), .chk_reset(chk_w[4]), .trig(trig_w[4]),
        .check(check_w[4]), .cycle(cyc_w[4]), .retired(ret_w[4]), .state(st_w[4]), .timeout(to_w[4]));
    rvfi_check_ctrl #(.NRET(1), .RESET_CYCLES(0), .TRIG_MODE(0), .TRIG_CYCLE(3), .TRIG_RETIRE(1), .CHECK_GAP(1)) u5 (
        .clock(clk), .reset(rst), .rvfi_valid(vld[5][0:0]), .chk_reset(chk_w[5]), .trig(trig_w[5]),
        .check(check_w[5]), .cycle(cyc_w[5]), .retired(ret_w[5]), .state(st_w[5]), .timeout(to_w[5]));

    task automatic check(input string name, input int inst, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s u%0d n=%0d: got %0d expected %0d", name, inst, n, act, exp);
        end
    endtask

    function automatic int popc(input logic [1:0] v, input int nret);
        return (nret == 2) ? (int'(v[0]) + int'(v[1])) : int'(v[0]);
    endfunction

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < NI; i++) begin
            racc[i]   = 0;
            trig_n[i] = -1;
        end
    endtask

    // Expected outputs follow from a timeline: armed from RC+1, trig at the first
    // armed cycle (<=255) meeting the condition, check GAP cycles later, then done.
    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            int pop    = popc(vld[i], cfg[i].nret);
            int armed  = cfg[i].rc + 1;
            int exp_st = 0;
            int exp_tr = 0;
            int exp_ck = 0;
            int exp_to = 0;
            if (trig_n[i] < 0 && n >= armed && n <= 255) begin
                if (cfg[i].mode == 0 ? (n == cfg[i].tc) : (racc[i] + pop >= cfg[i].tr))
                    trig_n[i] = n;
            end
            if (n < armed) begin
                exp_st = 0;
            end else if (trig_n[i] < 0) begin
                if (n <= 255) exp_st = 1;
                else begin
                    exp_st = 3;
                    exp_to = 1;
                end
            end else if (n == trig_n[i]) begin
                exp_st = 1;
                exp_tr = 1;
                exp_ck = (cfg[i].gap == 0) ? 1 : 0;
            end else if (n <= trig_n[i] + cfg[i].gap) begin
                exp_st = 2;
                exp_ck = (n == trig_n[i] + cfg[i].gap) ? 1 : 0;
            end else begin
                exp_st = 3;
            end
            check("chk_reset", i, chk_w[i], (n < cfg[i].rc) ? 1 : 0);
            check("cycle", i, cyc_w[i], (n > 255) ? 255 : n);
            check("retired", i, ret_w[i], (racc[i] > 65535) ? 65535 : racc[i]);
            check("state", i, st_w[i], exp_st);
            check("trig", i, trig_w[i], exp_tr);
            check("check", i, check_w[i], exp_ck);
            check("timeout", i, to_w[i], exp_to);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        compare_all();
    endtask

    task automatic advance_edge();
        for (int i = 0; i < NI; i++) begin
            if (n >= cfg[i].rc) racc[i] += popc(vld[i], cfg[i].nret);
        end
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) vld[i] = 2'b00;
        model_reset();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input int phase);
        vld[0] = {1'b0, 1'($urandom_range(0, 1))};
        if (phase == 1)
            vld[1] = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
        else
            vld[1] = 2'($urandom_range(0, 3));
        vld[2] = {1'b0, 1'($urandom_range(0, 1))};
        vld[3] = (phase == 0) ? 2'b00 : {1'b0, 1'($urandom_range(0, 1))};
        vld[4] = (n < 3) ? 2'b01 : {1'b0, ($urandom_range(0, 3) == 0)};
        vld[5] = {1'b0, 1'($urandom_range(0, 1))};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at n=%0d", n);
        $fatal(1);
    end

    initial begin
        cfg[0] = '{nret: 1, rc: 1, mode: 0, tc: 10, tr: 1, gap: 10};
        cfg[1] = '{nret: 2, rc: 1, mode: 1, tc: 10, tr: 3, gap: 10};
        cfg[2] = '{nret: 1, rc: 1, mode: 0, tc: 7,  tr: 1, gap: 0};
        cfg[3] = '{nret: 1, rc: 1, mode: 1, tc: 10, tr: 5, gap: 10};
        cfg[4] = '{nret: 1, rc: 3, mode: 1, tc: 10, tr: 4, gap: 2};
        cfg[5] = '{nret: 1, rc: 0, mode: 0, tc: 3,  tr: 1, gap: 1};

        // Two-channel retire at cycles 4 and 5 with threshold 3: trig is Mealy at cycle 5.
        tbl[0] = '{valid: 2'b00, exp_trig: 1'b0, exp_retired: 16'd0, exp_state: 2'd0};
        tbl[1] = '{valid: 2'b00, exp_trig: 1'b0, exp_retired: 16'd0, exp_state: 2'd0};
        tbl[2] = '{valid: 2'b00, exp_trig: 1'b0, exp_retired: 16'd0, exp_state: 2'd1};
        tbl[3] = '{valid: 2'b00, exp_trig: 1'b0, exp_retired: 16'd0, exp_state: 2'd1};
        tbl[4] = '{valid: 2'b11, exp_trig: 1'b0, exp_retired: 16'd0, exp_state: 2'd1};
        tbl[5] = '{valid: 2'b11, exp_trig: 1'b1, exp_retired: 16'd2, exp_state: 2'd1};
        tbl[6] = '{valid: 2'b00, exp_trig: 1'b0, exp_retired: 16'd4, exp_state: 2'd2};
        tbl[7] = '{valid: 2'b00, exp_trig: 1'b0, exp_retired: 16'd4, exp_state: 2'd2};

        for (int i = 0; i < NI; i++) vld[i] = 2'b00;
        model_reset();

        // Phase A: directed table on u1, long run to reach saturation and timeout.
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            drive(0);
            vld[1] = tbl[k].valid;
            sample();
            check("tbl_trig", 1, trig_w[1], tbl[k].exp_trig);
            check("tbl_retired", 1, ret_w[1], tbl[k].exp_retired);
            check("tbl_state", 1, st_w[1], tbl[k].exp_state);
            advance_edge();
        end
        for (int k = 8; k < 300; k++) begin
            drive(0);
            sample();
            advance_edge();
        end

        // Phase B: reset pulsed at cycle 15 while u0 waits for its check.
        apply_reset();
        for (int k = 0; k < 15; k++) begin
            drive(1);
            sample();
            advance_edge();
        end
        check("pre_abort_state", 0, st_w[0], 2);
        apply_reset();
        for (int k = 0; k < 300; k++) begin
            drive(1);
            sample();
            advance_edge();
        end

        // Phase C: short dense-random interval.
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            drive(2);
            sample();
            advance_edge();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
